// File: rtl/sub_d_pipe_if.sv
// rtl/sub_d_pipe_if.sv - handshake and result bundle for the sub_d_pipe channel combiner
interface sub_d_pipe_if #(
    parameter int NCH   = 3,
    parameter int W     = 1,
    parameter int DEPTH = 4,
    parameter int ACC_W = 16
) ();
    localparam int SW = W + $clog2(NCH);
    localparam int CW = $clog2(DEPTH + 1);

    logic                testi_valid_d;
    logic                testi_ready_d;
    logic [NCH*W-1:0]    testi_data_d;
    logic                testi_clr_d;
    logic                testo_valid_d;
    logic                testo_ready_d;
    logic [SW-1:0]       testo_sum_d;
    logic [W-1:0]        testo_par_d;
    logic [CW-1:0]       testo_cnt_d;
    logic [ACC_W-1:0]    testo_acc_d;

    modport master (
        output testi_valid_d, testi_data_d, testi_clr_d, testo_ready_d,
        input  testi_ready_d, testo_valid_d, testo_sum_d, testo_par_d,
               testo_cnt_d, testo_acc_d
    );

    modport slave (
        input  testi_valid_d, testi_data_d, testi_clr_d, testo_ready_d,
        output testi_ready_d, testo_valid_d, testo_sum_d, testo_par_d,
               testo_cnt_d, testo_acc_d
    );
endinterface

// File: rtl/sub_d_pipe.sv
// rtl/sub_d_pipe.sv - buffered NCH-channel sum/parity combiner with result FIFO
// Optional running accumulator of popped sums built when SUB_D_PIPE_ACC_EN is defined.
module sub_d_pipe #(
    parameter int NCH   = 3,
    parameter int W     = 1,
    parameter int DEPTH = 4,
    parameter int ACC_W = 16
) (
    input  logic        testi_clk_d,
    input  logic        testi_rst_n_d,
    sub_d_pipe_if.slave bus
);
    localparam int SW = W + $clog2(NCH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [SW-1:0] mem_sum [DEPTH];
    logic [W-1:0]  mem_par [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          ready_q;
    logic          push;
    logic          pop;
    logic          out_valid;
    logic [SW-1:0] beat_sum;
    logic [W-1:0]  beat_par;

    always_comb begin
        beat_sum = '0;
        beat_par = '0;
        for (int k = 0; k < NCH; k++) begin
            beat_sum = beat_sum + SW'(bus.testi_data_d[k*W +: W]);
            beat_par = beat_par ^ bus.testi_data_d[k*W +: W];
        end
    end

    assign out_valid = (cnt != '0);
    assign push      = bus.testi_valid_d && ready_q;
    assign pop       = out_valid && bus.testo_ready_d;
    assign cnt_nxt   = cnt + CW'(push) - CW'(pop);

    // Ready is registered from the next occupancy so it never asserts while full.
    always_ff @(posedge testi_clk_d or negedge testi_rst_n_d) begin
        if (!testi_rst_n_d) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            ready_q <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            ready_q <= (cnt_nxt < CW'(DEPTH));
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge testi_clk_d) begin
        if (push) begin
            mem_sum[wr_ptr] <= beat_sum;
            mem_par[wr_ptr] <= beat_par;
        end
    end

    assign bus.testi_ready_d = ready_q;
    assign bus.testo_valid_d = out_valid;
    assign bus.testo_sum_d   = out_valid ? mem_sum[rd_ptr] : '0;
    assign bus.testo_par_d   = out_valid ? mem_par[rd_ptr] : '0;
    assign bus.testo_cnt_d   = cnt;

`ifdef SUB_D_PIPE_ACC_EN
    logic [ACC_W-1:0] acc;

    // Clear wins over a same-cycle pop; the popped sum is dropped.
    always_ff @(posedge testi_clk_d or negedge testi_rst_n_d) begin
        if (!testi_rst_n_d) begin
            acc <= '0;
        end else if (bus.testi_clr_d) begin
            acc <= '0;
        end else if (pop) begin
            acc <= acc + ACC_W'(mem_sum[rd_ptr]);
        end
    end

    assign bus.testo_acc_d = acc;
`else
    logic unused_clr;
    assign unused_clr      = bus.testi_clr_d;
    assign bus.testo_acc_d = '0;
`endif
endmodule

// File: tb/tb_sub_d_pipe.sv
// tb/tb_sub_d_pipe.sv - self-checking bench for sub_d_pipe against a queue model
module tb_sub_d_pipe;
    localparam int NCH   = 3;
    localparam int W     = 1;
    localparam int DEPTH = 4;
    localparam int ACC_W = 16;
    localparam longint ACC_MOD = longint'(1) << ACC_W;
`ifdef SUB_D_PIPE_ACC_EN
    localparam int ACC_ON = 1;
`else
    localparam int ACC_ON = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sub_d_pipe_if #(.NCH(NCH), .W(W), .DEPTH(DEPTH), .ACC_W(ACC_W)) bus ();

    sub_d_pipe #(.NCH(NCH), .W(W), .DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
        .testi_clk_d   (clk),
        .testi_rst_n_d (rst_n),
        .bus           (bus)
    );

    int     nerr = 0;
    int     nchk = 0;
    int     q_sum[$];
    int     q_par[$];
    longint m_acc = 0;
    bit     m_ready = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int hs;
        int hp;
        hs = (q_sum.size() != 0) ? q_sum[0] : 0;
        hp = (q_par.size() != 0) ? q_par[0] : 0;
        chk("ready", 32'(bus.testi_ready_d), 32'(m_ready));
        chk("valid", 32'(bus.testo_valid_d), 32'(q_sum.size() != 0));
        chk("sum",   32'(bus.testo_sum_d), 32'(hs));
        chk("par",   32'(bus.testo_par_d), 32'(hp));
        chk("cnt",   32'(bus.testo_cnt_d), 32'(q_sum.size()));
        chk("acc",   32'(bus.testo_acc_d), 32'(m_acc));
    endtask

    // One clock: drive inputs, advance the model on the edge, compare 1 time unit later.
    task automatic cyc(input bit v, input logic [NCH*W-1:0] d, input bit ordy, input bit clr);
        bit do_push;
        bit do_pop;
        int s;
        int p;
        bus.testi_valid_d = v;
        bus.testi_data_d  = d;
        bus.testo_ready_d = ordy;
        bus.testi_clr_d   = clr;
        do_push = v && m_ready;
        do_pop  = (q_sum.size() != 0) && ordy;
        s = 0;
        p = 0;
        for (int k = 0; k < NCH; k++) begin
            s = s + int'(d[k*W +: W]);
            p = p ^ int'(d[k*W +: W]);
        end
        @(posedge clk);
        if (rst_n) begin
            if (ACC_ON != 0) begin
                if (clr) m_acc = 0;
                else if (do_pop) m_acc = (m_acc + q_sum[0]) % ACC_MOD;
            end
            if (do_pop) begin
                q_sum.delete(0);
                q_par.delete(0);
            end
            if (do_push) begin
                q_sum.push_back(s);
                q_par.push_back(p);
            end
            m_ready = (q_sum.size() < DEPTH);
        end
        #1;
        check_all();
    endtask

    initial begin
        bus.testi_valid_d = 1'b0;
        bus.testi_data_d  = '0;
        bus.testo_ready_d = 1'b0;
        bus.testi_clr_d   = 1'b0;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) cyc(0, '0, 0, 0);
        chk("rst_ready", 32'(bus.testi_ready_d), 0);
        chk("rst_cnt", 32'(bus.testo_cnt_d), 0);
        rst_n = 1'b1;
        cyc(0, '0, 0, 0);
        chk("ready_after_rst", 32'(bus.testi_ready_d), 1);

        // Single beat and second entry
        cyc(1, 3'b111, 0, 0);
        chk("single_valid", 32'(bus.testo_valid_d), 1);
        chk("single_sum", 32'(bus.testo_sum_d), 3);
        chk("single_par", 32'(bus.testo_par_d), 1);
        chk("single_cnt", 32'(bus.testo_cnt_d), 1);
        cyc(1, 3'b101, 0, 0);
        cyc(0, '0, 1, 0);
        chk("second_sum", 32'(bus.testo_sum_d), 2);
        chk("second_par", 32'(bus.testo_par_d), 0);
        cyc(0, '0, 1, 0);
        chk("drained_cnt", 32'(bus.testo_cnt_d), 0);

        // Full FIFO and held-off fifth beat
        cyc(1, 3'b001, 0, 0);
        cyc(1, 3'b011, 0, 0);
        cyc(1, 3'b111, 0, 0);
        cyc(1, 3'b000, 0, 0);
        chk("full_cnt", 32'(bus.testo_cnt_d), 4);
        chk("full_ready", 32'(bus.testi_ready_d), 0);
        cyc(1, 3'b110, 0, 0);
        cyc(1, 3'b110, 0, 0);
        chk("fifth_rejected_cnt", 32'(bus.testo_cnt_d), 4);
        chk("full_head_sum", 32'(bus.testo_sum_d), 1);
        for (int i = 0; i < 4; i++) cyc(0, '0, 1, 0);
        chk("full_drained", 32'(bus.testo_cnt_d), 0);

        // Concurrent push/pop across pointer wrap
        cyc(1, 3'(unsigned'($urandom)), 0, 0);
        cyc(1, 3'(unsigned'($urandom)), 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 3'(unsigned'($urandom)), 1, 0);
            chk("concurrent_cnt", 32'(bus.testo_cnt_d), 2);
        end
        cyc(0, '0, 1, 0);
        cyc(0, '0, 1, 0);

        // Accumulator
        cyc(0, '0, 0, 1);
        cyc(1, 3'b111, 0, 0);
        cyc(1, 3'b101, 0, 0);
        cyc(1, 3'b001, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0);
        chk("acc_six", 32'(bus.testo_acc_d), 32'(6 * ACC_ON));
        cyc(1, 3'b111, 0, 0);
        cyc(0, '0, 1, 1);
        chk("acc_clr_pop", 32'(bus.testo_acc_d), 0);

        // Reset mid-stream with three entries queued
        cyc(1, 3'b011, 0, 0);
        cyc(1, 3'b010, 0, 0);
        cyc(1, 3'b111, 0, 0);
        chk("pre_reset_cnt", 32'(bus.testo_cnt_d), 3);
        rst_n = 1'b0;
        #1;
        q_sum.delete();
        q_par.delete();
        m_acc = 0;
        m_ready = 1'b0;
        chk("async_rst_cnt", 32'(bus.testo_cnt_d), 0);
        chk("async_rst_valid", 32'(bus.testo_valid_d), 0);
        check_all();
        cyc(0, '0, 0, 0);
        rst_n = 1'b1;
        cyc(0, '0, 0, 0);

        // Random backpressure
        for (int i = 0; i < 200; i++) begin
            cyc(bit'($urandom_range(1)), 3'(unsigned'($urandom)), bit'($urandom_range(1)),
                bit'($urandom_range(15) == 0));
            nchk++;
            assert (bus.testo_cnt_d <= 3'(DEPTH)) else begin
                nerr++;
                $error("FAIL cnt_bound observed=%0d expected<=%0d", bus.testo_cnt_d, DEPTH);
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/sub_d_pipe.md
# sub_d_pipe

Parametrised, buffered successor to the single-cycle channel combiner in the `sub_d` hierarchy. It accepts NCH channels of W-bit data per beat under a valid/ready handshake and computes their arithmetic sum and bitwise XOR parity. Results are queued in a DEPTH-entry FIFO and presented downstream under a second valid/ready handshake. An optional running accumulator sums the popped results.

## Interface
- `NCH`, default 3: number of input channels, ≥1.
- `W`, default 1: bits per channel, ≥1.
- `DEPTH`, default 4: FIFO entries; power of 2, ≥2.
- `ACC_W`, default 16: accumulator width.
- Derived `SW` = W + $clog2(NCH), the sum width. `CW` = $clog2(DEPTH+1), the count width.
- `testi_clk_d`  in  1  sole clock; all state changes on its rising edge.
- `testi_rst_n_d`  in  1  reset; asynchronous assert, active-low.
- `testi_valid_d`  in  1  input beat valid.
- `testi_ready_d`  out  1  block can accept a beat.
- `testi_data_d`  in  NCH*W  channel k occupies bits [k*W +: W].
- `testi_clr_d`  in  1  synchronous accumulator clear.
- `testo_valid_d`  out  1  head entry valid.
- `testo_ready_d`  in  1  downstream accepts head.
- `testo_sum_d`  out  SW  head sum.
- `testo_par_d`  out  W  head parity.
- `testo_cnt_d`  out  CW  FIFO occupancy.
- `testo_acc_d`  out  ACC_W  running accumulator.

## Operation
- **Push.** A push occurs when `testi_valid_d && testi_ready_d`.
  - The entry stores sum = unsigned sum of all NCH channels, zero-extended to SW (never overflows).
  - The entry stores par = XOR of all NCH channels.
- **Pop.** A pop occurs when `testo_valid_d && testo_ready_d`. The entry at the read pointer is retired.
- **Pointers.** Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Count tracks occupancy 0..DEPTH.
- **Ready.** `testi_ready_d` is a register equal to (next count < DEPTH). Ready is never asserted while the FIFO is full, and a full FIFO does not pass data through.
- **Output.** `testo_valid_d` = (count != 0). `testo_sum_d` and `testo_par_d` show the head entry when valid and are forced to 0 when empty.
- **Simultaneous push and pop.** With 0 < count < DEPTH, both occur and count is unchanged.
- **Push while empty.** The entry appears at the output on the next cycle; there is no combinational bypass.
- **Ignored inputs.** `testi_data_d` is ignored when no push occurs. A valid beat offered while not ready is held off; it is neither dropped nor duplicated.
- **Accumulator (macro only).**
  - On a pop: acc ← acc + zero-extended head sum, modulo 2^ACC_W.
  - `testi_clr_d` has priority over a same-cycle pop: acc ← 0 and the popped sum is discarded from acc.
- **Reset mid-operation.** Contents are discarded. Pointers and count clear immediately (asynchronously).

## Timing
- Reset values: `testi_ready_d`=0, `testo_valid_d`=0, `testo_sum_d`=0, `testo_par_d`=0, `testo_cnt_d`=0, `testo_acc_d`=0.
- `testi_ready_d` rises on the first rising edge after `testi_rst_n_d` deasserts.
- Latency: a push at edge N gives `testo_valid_d`=1 after edge N, with the result visible in cycle N+1.
- Throughput: one beat per cycle sustained while downstream is ready.
- `testo_cnt_d` and `testo_acc_d` are registered and update on the same edge as the push or pop.
- Reset deassertion must be synchronised externally to `testi_clk_d`.

## Configuration
- Macro `SUB_D_PIPE_ACC_EN`.
- **Defined:** the accumulator is built and `testo_acc_d` behaves as described in Operation.
- **Undefined:** there is no accumulator logic, `testo_acc_d` is tied to 0, and `testi_clr_d` is ignored. All other behaviour is identical.

## Test plan
All scenarios use defaults NCH=3, W=1, DEPTH=4, with `SUB_D_PIPE_ACC_EN` defined unless noted.
- **Reset.** Hold `testi_rst_n_d`=0 for 3 cycles → all outputs 0. Release → `testi_ready_d`=1 one edge later. Assert reset mid-stream with cnt=3 → cnt=0 and `testo_valid_d`=0 immediately, without waiting for a clock.
- **Single beat.** Push data 3'b111 with `testo_ready_d`=0 → next cycle `testo_valid_d`=1, sum=3, par=1, cnt=1. Push 3'b101 → second entry holds sum=2, par=0.
- **Full.** Push 4 beats (3'b001, 3'b011, 3'b111, 3'b000) with `testo_ready_d`=0 → cnt=4, `testi_ready_d`=0, and a fifth valid beat is not accepted. Then raise `testo_ready_d` → sums 1, 2, 3, 0 pop in order and cnt returns to 0.
- **Concurrent and wrap.** Stream 10 beats with both sides ready at cnt=2 → cnt stays 2 throughout, outputs match inputs in order across pointer wrap, and nothing is lost or duplicated.
- **Accumulator.** Pop sums 3, 2, 1 → acc=6. Assert `testi_clr_d` in the same cycle as a pop of sum 3 → acc=0. With the macro undefined → acc stays 0 throughout.
- **Backpressure toggle.** Toggle `testo_ready_d` randomly for 200 cycles → scoreboard matches every sum and parity and cnt never exceeds 4.
